mem_access_unit: RTL and testbench

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_unit_pkg.sv | 53 +++++
 rtl/mem_access_unit_if.sv | 20 ++
 rtl/mem_access_unit_load_align.sv | 33 +++
 rtl/mem_access_unit.sv | 137 +++++++++++++
 tb/tb_mem_access_unit.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_access_unit_pkg.sv
// Shared types, funct3 codes and access helpers for the EX/MEM memory access unit.
// Alignment, strobe and lane-replication rules live here so the FSM stays readable.
package mem_access_unit_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

  // Size comes from funct3[1:0]; the unused size code 11 is held to word alignment.
  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr);
    case (funct3[1:0])
      2'b00:   return 1'b0;
      2'b01:   return addr[0];
      default: return |addr;
    endcase
  endfunction

  function automatic logic [3:0] store_strobe(input logic [2:0] funct3, input logic [1:0] addr);
    case (funct3)
      F3_SB:   return 4'b0001 << addr;
      F3_SH:   return 4'b0011 << {addr[1], 1'b0};
      F3_SW:   return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic [31:0] store_wdata(input logic [2:0] funct3, input logic [31:0] rs2);
    case (funct3)
      F3_SB:   return {4{rs2[7:0]}};
      F3_SH:   return {2{rs2[15:0]}};
      default: return rs2;
    endcase
  endfunction

  function automatic logic load_code_valid(input logic [2:0] funct3);
    return (funct3 == F3_LB) || (funct3 == F3_LH) || (funct3 == F3_LW) ||
           (funct3 == F3_LBU) || (funct3 == F3_LHU);
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Data-memory bus between the access unit (master) and the memory (slave).
interface mem_access_unit_if;
  logic        dmem_req_o;
  logic        dmem_we_o;
  logic [31:0] dmem_addr_o;
  logic [3:0]  dmem_wstrb_o;
  logic [31:0] dmem_wdata_o;
  logic        dmem_ack_i;
  logic [31:0] dmem_rdata_i;

  modport master (
    output dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wstrb_o, dmem_wdata_o,
    input  dmem_ack_i, dmem_rdata_i
  );

  modport slave (
    input  dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wstrb_o, dmem_wdata_o,
    output dmem_ack_i, dmem_rdata_i
  );
endinterface

// File: rtl/mem_access_unit_load_align.sv
// Picks the addressed byte/halfword out of a read word and sign- or zero-extends it.
module load_align
  import mem_access_unit_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  addr_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] result_o
);

  logic [7:0]  loadByte;
  logic [15:0] loadHalf;

  always_comb begin
    case (addr_i)
      2'd0:    loadByte = rdata_i[7:0];
      2'd1:    loadByte = rdata_i[15:8];
      2'd2:    loadByte = rdata_i[23:16];
      default: loadByte = rdata_i[31:24];
    endcase
    loadHalf = addr_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    case (funct3_i)
      F3_LB:   result_o = {{24{loadByte[7]}}, loadByte};
      F3_LH:   result_o = {{16{loadHalf[15]}}, loadHalf};
      F3_LW:   result_o = rdata_i;
      F3_LBU:  result_o = {24'h00_0000, loadByte};
      F3_LHU:  result_o = {16'h0000, loadHalf};
      default: result_o = ZERO_WORD;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage access unit: issues one bus transaction per load/store, stalls the
// pipeline while it is outstanding, and aborts it after TIMEOUT_CYCLES without ack.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               valid_i,
  input  logic [31:0]        alu_result_i,
  input  logic [31:0]        rs2_data_i,
  input  logic               MemRead_i,
  input  logic               MemWrite_i,
  input  logic [2:0]         funct3_i,
  input  logic               RegWrite_i,
  input  logic [4:0]         Rd_i,
  mem_access_unit_if.master  dmem,
  output logic [31:0]        load_or_result_o,
  output logic               RegWrite_o,
  output logic [4:0]         Rd_o,
  output logic               stall_o,
  output logic               misalign_o,
  output logic               bus_err_o
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             req_q;
  logic             we_q;
  logic [31:0]      addr_q;
  logic [3:0]       wstrb_q;
  logic [31:0]      wdata_q;
  logic [31:0]      rdata_q;
  logic             misalign_q;
  logic             bus_err_q;

  logic        memOp;
  logic        loadOp;
  logic        misaligned;
  logic [31:0] loadData;

  assign memOp      = valid_i & (MemRead_i | MemWrite_i);
  assign loadOp     = valid_i & MemRead_i & ~MemWrite_i;
  assign misaligned = is_misaligned(funct3_i, alu_result_i[1:0]);

  load_align uLoadAlign (
    .rdata_i  (rdata_q),
    .addr_i   (alu_result_i[1:0]),
    .funct3_i (funct3_i),
    .result_o (loadData)
  );

  // Bus fields are latched on entry to BUSY and dropped on ack or timeout, so a
  // late ack arriving in DONE/IDLE finds no request and changes nothing.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= ZERO_WORD;
      wstrb_q    <= 4'b0000;
      wdata_q    <= ZERO_WORD;
      rdata_q    <= ZERO_WORD;
      misalign_q <= 1'b0;
      bus_err_q  <= 1'b0;
    end else begin
      misalign_q <= 1'b0;
      bus_err_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (memOp && misaligned) begin
            misalign_q <= 1'b1;
          end else if (memOp) begin
            state_q <= S_BUSY;
            cnt_q   <= '0;
            req_q   <= 1'b1;
            we_q    <= MemWrite_i;
            addr_q  <= {alu_result_i[31:2], 2'b00};
            wstrb_q <= MemWrite_i ? store_strobe(funct3_i, alu_result_i[1:0]) : 4'b0000;
            wdata_q <= MemWrite_i ? store_wdata(funct3_i, rs2_data_i) : ZERO_WORD;
          end
        end
        S_BUSY: begin
          if (dmem.dmem_ack_i || cnt_q == CNT_LAST) begin
            state_q   <= S_DONE;
            cnt_q     <= '0;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= ZERO_WORD;
            wstrb_q   <= 4'b0000;
            wdata_q   <= ZERO_WORD;
            rdata_q   <= dmem.dmem_ack_i ? dmem.dmem_rdata_i : ZERO_WORD;
            bus_err_q <= ~dmem.dmem_ack_i;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // bus_err_q is high exactly in the DONE cycle following a timeout.
  always_comb begin
    load_or_result_o = alu_result_i;
    RegWrite_o       = 1'b0;
    Rd_o             = Rd_i;
    stall_o          = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!memOp) RegWrite_o = RegWrite_i & valid_i;
        else        stall_o    = ~misaligned;
      end
      S_BUSY: stall_o = 1'b1;
      S_DONE: begin
        load_or_result_o = (loadOp && !bus_err_q) ? loadData : ZERO_WORD;
        RegWrite_o       = RegWrite_i & loadOp & ~bus_err_q & load_code_valid(funct3_i);
      end
      default: stall_o = 1'b0;
    endcase
  end

  assign dmem.dmem_req_o   = req_q;
  assign dmem.dmem_we_o    = we_q;
  assign dmem.dmem_addr_o  = addr_q;
  assign dmem.dmem_wstrb_o = wstrb_q;
  assign dmem.dmem_wdata_o = wdata_q;
  assign misalign_o        = misalign_q;
  assign bus_err_o         = bus_err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with TIMEOUT_CYCLES=4; inputs change on the
// falling edge and outputs are sampled there, away from the active rising edge.
module tb_mem_access_unit;
  import mem_access_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid;
  logic [31:0] aluResult;
  logic [31:0] rs2Data;
  logic        memRead;
  logic        memWrite;
  logic [2:0]  funct3;
  logic        regWriteIn;
  logic [4:0]  rdIn;
  logic [31:0] loadOrResult;
  logic        regWriteOut;
  logic [4:0]  rdOut;
  logic        stall;
  logic        misalign;
  logic        busErr;

  int checks = 0;
  int failures = 0;

  mem_access_unit_if bus ();

  mem_access_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .valid_i          (valid),
    .alu_result_i     (aluResult),
    .rs2_data_i       (rs2Data),
    .MemRead_i        (memRead),
    .MemWrite_i       (memWrite),
    .funct3_i         (funct3),
    .RegWrite_i       (regWriteIn),
    .Rd_i             (rdIn),
    .dmem             (bus),
    .load_or_result_o (loadOrResult),
    .RegWrite_o       (regWriteOut),
    .Rd_o             (rdOut),
    .stall_o          (stall),
    .misalign_o       (misalign),
    .bus_err_o        (busErr)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic step;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clearInputs;
    valid = 1'b0; aluResult = '0; rs2Data = '0; memRead = 1'b0; memWrite = 1'b0;
    funct3 = 3'b000; regWriteIn = 1'b0; rdIn = '0;
  endtask

  task automatic driveOp(input logic isLoad, input logic isStore, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] data,
                         input logic [4:0] rd, input logic rw);
    valid = 1'b1; memRead = isLoad; memWrite = isStore; funct3 = f3;
    aluResult = addr; rs2Data = data; rdIn = rd; regWriteIn = rw;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    step();
    step();
    checks++; if (bus.dmem_req_o !== 1'b0) begin failures++; $display("[TB] FAIL reset_req: got %b want 0", bus.dmem_req_o); end
    checks++; if (bus.dmem_we_o !== 1'b0) begin failures++; $display("[TB] FAIL reset_we: got %b want 0", bus.dmem_we_o); end
    checks++; if (bus.dmem_addr_o !== 32'h0) begin failures++; $display("[TB] FAIL reset_addr: got %h want 0", bus.dmem_addr_o); end
    checks++; if (bus.dmem_wstrb_o !== 4'h0) begin failures++; $display("[TB] FAIL reset_wstrb: got %b want 0000", bus.dmem_wstrb_o); end
    checks++; if (bus.dmem_wdata_o !== 32'h0) begin failures++; $display("[TB] FAIL reset_wdata: got %h want 0", bus.dmem_wdata_o); end
    checks++; if (misalign !== 1'b0) begin failures++; $display("[TB] FAIL reset_misalign: got %b want 0", misalign); end
    checks++; if (busErr !== 1'b0) begin failures++; $display("[TB] FAIL reset_bus_err: got %b want 0", busErr); end
    checks++; if (stall !== 1'b0) begin failures++; $display("[TB] FAIL reset_stall: got %b want 0", stall); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_passthrough;
    driveOp(1'b0, 1'b0, 3'b000, 32'h1234_5678, 32'h0, 5'd7, 1'b1);
    #1;
    checks++; if (loadOrResult !== 32'h1234_5678) begin failures++; $display("[TB] FAIL pass_result: got %h want 12345678", loadOrResult); end
    checks++; if (regWriteOut !== 1'b1) begin failures++; $display("[TB] FAIL pass_regwrite: got %b want 1", regWriteOut); end
    checks++; if (rdOut !== 5'd7) begin failures++; $display("[TB] FAIL pass_rd: got %0d want 7", rdOut); end
    checks++; if (stall !== 1'b0) begin failures++; $display("[TB] FAIL pass_stall: got %b want 0", stall); end
    valid = 1'b0; memRead = 1'b1;
    #1;
    checks++; if (regWriteOut !== 1'b0) begin failures++; $display("[TB] FAIL pass_invalid_regwrite: got %b want 0", regWriteOut); end
    checks++; if (stall !== 1'b0) begin failures++; $display("[TB] FAIL pass_invalid_stall: got %b want 0", stall); end
    step();
    checks++; if (bus.dmem_req_o !== 1'b0) begin failures++; $display("[TB] FAIL pass_invalid_req: got %b want 0", bus.dmem_req_o); end
    clearInputs();
    step();
  endtask

  task automatic test_lw;
    int stallCycles = 0;
    driveOp(1'b1, 1'b0, F3_LW, 32'h0000_0100, 32'h0, 5'd5, 1'b1);
    #1;
    stallCycles += int'(stall);
    checks++; if (stall !== 1'b1) begin failures++; $display("[TB] FAIL lw_idle_stall: got %b want 1", stall); end
    checks++; if (regWriteOut !== 1'b0) begin failures++; $display("[TB] FAIL lw_idle_regwrite: got %b want 0", regWriteOut); end
    step();
    stallCycles += int'(stall);
    checks++; if (bus.dmem_req_o !== 1'b1) begin failures++; $display("[TB] FAIL lw_busy_req: got %b want 1", bus.dmem_req_o); end
    checks++; if (bus.dmem_we_o !== 1'b0) begin failures++; $display("[TB] FAIL lw_busy_we: got %b want 0", bus.dmem_we_o); end
    checks++; if (bus.dmem_addr_o !== 32'h0000_0100) begin failures++; $display("[TB] FAIL lw_busy_addr: got %h want 00000100", bus.dmem_addr_o); end
    bus.dmem_ack_i = 1'b1; bus.dmem_rdata_i = 32'hDEAD_BEEF;
    step();
    bus.dmem_ack_i = 1'b0; bus.dmem_rdata_i = 32'h0;
    stallCycles += int'(stall);
    checks++; if (loadOrResult !== 32'hDEAD_BEEF) begin failures++; $display("[TB] FAIL lw_done_result: got %h want deadbeef", loadOrResult); end
    checks++; if (regWriteOut !== 1'b1) begin failures++; $display("[TB] FAIL lw_done_regwrite: got %b want 1", regWriteOut); end
    checks++; if (rdOut !== 5'd5) begin failures++; $display("[TB] FAIL lw_done_rd: got %0d want 5", rdOut); end
    checks++; if (bus.dmem_req_o !== 1'b0) begin failures++; $display("[TB] FAIL lw_done_req: got %b want 0", bus.dmem_req_o); end
    checks++; if (stallCycles != 2) begin failures++; $display("[TB] FAIL lw_stall_cycles: got %0d want 2", stallCycles); end
    clearInputs();
    step();
  endtask

  task automatic test_loads;
    logic [2:0]  f3s   [5] = '{F3_LB, F3_LBU, F3_LH, F3_LHU, 3'b011};
    logic [31:0] addrs [5] = '{32'h103, 32'h103, 32'h102, 32'h100, 32'h100};
    logic [31:0] exps  [5] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80FF, 32'h0000_FF00, 32'h0};
    logic        wes   [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 5; i++) begin
      driveOp(1'b1, 1'b0, f3s[i], addrs[i], 32'h0, 5'd10, 1'b1);
      step();
      checks++; if (bus.dmem_addr_o !== (addrs[i] & 32'hFFFF_FFFC)) begin failures++; $display("[TB] FAIL load%0d_addr: got %h want %h", i, bus.dmem_addr_o, addrs[i] & 32'hFFFF_FFFC); end
      bus.dmem_ack_i = 1'b1; bus.dmem_rdata_i = 32'h80FF_FF00;
      step();
      bus.dmem_ack_i = 1'b0;
      checks++; if (loadOrResult !== exps[i]) begin failures++; $display("[TB] FAIL load%0d_result: got %h want %h", i, loadOrResult, exps[i]); end
      checks++; if (regWriteOut !== wes[i]) begin failures++; $display("[TB] FAIL load%0d_regwrite: got %b want %b", i, regWriteOut, wes[i]); end
      clearInputs();
      step();
    end
  endtask

  task automatic test_stores;
    logic [2:0]  f3s   [4] = '{F3_SH, F3_SB, F3_SW, F3_SB};
    logic [31:0] addrs [4] = '{32'h102, 32'h101, 32'h104, 32'h103};
    logic [31:0] datas [4] = '{32'h1234_ABCD, 32'h0000_00A5, 32'hCAFE_F00D, 32'h0000_007E};
    logic [3:0]  strbs [4] = '{4'b1100, 4'b0010, 4'b1111, 4'b1000};
    logic [31:0] wdats [4] = '{32'hABCD_ABCD, 32'hA5A5_A5A5, 32'hCAFE_F00D, 32'h7E7E_7E7E};
    for (int i = 0; i < 4; i++) begin
      driveOp(1'b0, 1'b1, f3s[i], addrs[i], datas[i], 5'd3, 1'b1);
      #1;
      checks++; if (stall !== 1'b1) begin failures++; $display("[TB] FAIL store%0d_idle_stall: got %b want 1", i, stall); end
      step();
      checks++; if (bus.dmem_we_o !== 1'b1) begin failures++; $display("[TB] FAIL store%0d_we: got %b want 1", i, bus.dmem_we_o); end
      checks++; if (bus.dmem_wstrb_o !== strbs[i]) begin failures++; $display("[TB] FAIL store%0d_wstrb: got %b want %b", i, bus.dmem_wstrb_o, strbs[i]); end
      checks++; if (bus.dmem_wdata_o !== wdats[i]) begin failures++; $display("[TB] FAIL store%0d_wdata: got %h want %h", i, bus.dmem_wdata_o, wdats[i]); end
      checks++; if (regWriteOut !== 1'b0) begin failures++; $display("[TB] FAIL store%0d_busy_regwrite: got %b want 0", i, regWriteOut); end
      step();
      checks++; if (bus.dmem_req_o !== 1'b1 || bus.dmem_wstrb_o !== strbs[i] || bus.dmem_wdata_o !== wdats[i])
        begin failures++; $display("[TB] FAIL store%0d_hold: req %b wstrb %b wdata %h want 1 %b %h", i, bus.dmem_req_o, bus.dmem_wstrb_o, bus.dmem_wdata_o, strbs[i], wdats[i]); end
      bus.dmem_ack_i = 1'b1;
      step();
      bus.dmem_ack_i = 1'b0;
      checks++; if (regWriteOut !== 1'b0) begin failures++; $display("[TB] FAIL store%0d_done_regwrite: got %b want 0", i, regWriteOut); end
      checks++; if (stall !== 1'b0 || bus.dmem_req_o !== 1'b0) begin failures++; $display("[TB] FAIL store%0d_done: stall %b req %b want 0 0", i, stall, bus.dmem_req_o); end
      clearInputs();
      step();
    end
  endtask

  task automatic test_misalign;
    logic        lds   [3] = '{1'b1, 1'b1, 1'b0};
    logic [2:0]  f3s   [3] = '{F3_LW, F3_LH, F3_SW};
    logic [31:0] addrs [3] = '{32'h101, 32'h103, 32'h102};
    for (int i = 0; i < 3; i++) begin
      driveOp(lds[i], ~lds[i], f3s[i], addrs[i], 32'h5555_5555, 5'd8, 1'b1);
      #1;
      checks++; if (stall !== 1'b0) begin failures++; $display("[TB] FAIL mis%0d_stall: got %b want 0", i, stall); end
      checks++; if (regWriteOut !== 1'b0) begin failures++; $display("[TB] FAIL mis%0d_regwrite: got %b want 0", i, regWriteOut); end
      step();
      clearInputs();
      checks++; if (misalign !== 1'b1) begin failures++; $display("[TB] FAIL mis%0d_pulse: got %b want 1", i, misalign); end
      checks++; if (bus.dmem_req_o !== 1'b0) begin failures++; $display("[TB] FAIL mis%0d_req: got %b want 0", i, bus.dmem_req_o); end
      step();
      checks++; if (misalign !== 1'b0 || bus.dmem_req_o !== 1'b0) begin failures++; $display("[TB] FAIL mis%0d_after: misalign %b req %b want 0 0", i, misalign, bus.dmem_req_o); end
    end
  endtask

  task automatic test_timeout;
    driveOp(1'b1, 1'b0, F3_LW, 32'h0000_0200, 32'h0, 5'd9, 1'b1);
    step();
    for (int c = 0; c < 4; c++) begin
      checks++; if (bus.dmem_req_o !== 1'b1 || stall !== 1'b1 || busErr !== 1'b0)
        begin failures++; $display("[TB] FAIL timeout_busy%0d: req %b stall %b err %b want 1 1 0", c, bus.dmem_req_o, stall, busErr); end
      step();
    end
    checks++; if (busErr !== 1'b1) begin failures++; $display("[TB] FAIL timeout_err: got %b want 1", busErr); end
    checks++; if (regWriteOut !== 1'b0) begin failures++; $display("[TB] FAIL timeout_regwrite: got %b want 0", regWriteOut); end
    checks++; if (stall !== 1'b0 || bus.dmem_req_o !== 1'b0) begin failures++; $display("[TB] FAIL timeout_done: stall %b req %b want 0 0", stall, bus.dmem_req_o); end
    checks++; if (loadOrResult !== 32'h0) begin failures++; $display("[TB] FAIL timeout_result: got %h want 0", loadOrResult); end
    bus.dmem_ack_i = 1'b1; bus.dmem_rdata_i = 32'h1234_5678;
    clearInputs();
    step();
    checks++; if (busErr !== 1'b0 || bus.dmem_req_o !== 1'b0 || stall !== 1'b0)
      begin failures++; $display("[TB] FAIL timeout_idle: err %b req %b stall %b want 0 0 0", busErr, bus.dmem_req_o, stall); end
    driveOp(1'b0, 1'b0, 3'b000, 32'h0000_00AA, 32'h0, 5'd4, 1'b1);
    #1;
    checks++; if (regWriteOut !== 1'b1 || loadOrResult !== 32'h0000_00AA)
      begin failures++; $display("[TB] FAIL timeout_late_ack: regwrite %b result %h want 1 000000aa", regWriteOut, loadOrResult); end
    step();
    bus.dmem_ack_i = 1'b0; bus.dmem_rdata_i = 32'h0;
    clearInputs();
    step();
  endtask

  task automatic test_reset_busy;
    driveOp(1'b1, 1'b0, F3_LW, 32'h0000_0300, 32'h0, 5'd6, 1'b1);
    step();
    checks++; if (bus.dmem_req_o !== 1'b1) begin failures++; $display("[TB] FAIL rstbusy_req_before: got %b want 1", bus.dmem_req_o); end
    rst_n = 1'b0;
    clearInputs();
    step();
    checks++; if (bus.dmem_req_o !== 1'b0 || stall !== 1'b0 || bus.dmem_addr_o !== 32'h0)
      begin failures++; $display("[TB] FAIL rstbusy_abort: req %b stall %b addr %h want 0 0 0", bus.dmem_req_o, stall, bus.dmem_addr_o); end
    rst_n = 1'b1;
    bus.dmem_ack_i = 1'b1; bus.dmem_rdata_i = 32'h0000_0055;
    step();
    bus.dmem_ack_i = 1'b0;
    checks++; if (regWriteOut !== 1'b0 || bus.dmem_req_o !== 1'b0 || stall !== 1'b0 || busErr !== 1'b0)
      begin failures++; $display("[TB] FAIL rstbusy_late_ack: regwrite %b req %b stall %b err %b want 0 0 0 0", regWriteOut, bus.dmem_req_o, stall, busErr); end
    step();
  endtask

  task automatic test_back_to_back;
    driveOp(1'b1, 1'b0, F3_LW, 32'h0000_0010, 32'h0, 5'd1, 1'b1);
    step();
    bus.dmem_ack_i = 1'b1; bus.dmem_rdata_i = 32'h1111_1111;
    step();
    bus.dmem_ack_i = 1'b0;
    checks++; if (loadOrResult !== 32'h1111_1111 || regWriteOut !== 1'b1)
      begin failures++; $display("[TB] FAIL b2b_first: result %h regwrite %b want 11111111 1", loadOrResult, regWriteOut); end
    driveOp(1'b1, 1'b0, F3_LBU, 32'h0000_0012, 32'h0, 5'd2, 1'b1);
    step();
    checks++; if (stall !== 1'b1 || bus.dmem_req_o !== 1'b0)
      begin failures++; $display("[TB] FAIL b2b_second_idle: stall %b req %b want 1 0", stall, bus.dmem_req_o); end
    step();
    bus.dmem_ack_i = 1'b1; bus.dmem_rdata_i = 32'h00AB_0000;
    step();
    bus.dmem_ack_i = 1'b0;
    checks++; if (loadOrResult !== 32'h0000_00AB || regWriteOut !== 1'b1 || rdOut !== 5'd2)
      begin failures++; $display("[TB] FAIL b2b_second: result %h regwrite %b rd %0d want 000000ab 1 2", loadOrResult, regWriteOut, rdOut); end
    clearInputs();
    step();
  endtask

  initial begin
    bus.dmem_ack_i = 1'b0;
    bus.dmem_rdata_i = 32'h0;
    clearInputs();
    rst_n = 1'b0;
    test_reset();
    test_passthrough();
    test_lw();
    test_loads();
    test_stores();
    test_misalign();
    test_timeout();
    test_reset_busy();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
